// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, region bases,
// RV32 funct3 encodings and the encoding legality check.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PEND  = 2'd1,
      ST_SPLIT = 2'd2,
      ST_FLT   = 2'd3
   } lsu_state_t;

   typedef struct packed {
      logic       write;
      logic [2:0] funct3;
   } lsu_opcode_t;

   localparam logic [15:0] ROM_BASE_DEF  = 16'h0000;
   localparam logic [15:0] MMIO_BASE_DEF = 16'h7000;
   localparam logic [15:0] RAM_BASE_DEF  = 16'h8000;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   function automatic logic funct3_legal(input logic write, input logic [2:0] f3);
      logic ok;
      if (write) begin
         ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
      end else begin
         ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
              (f3 == F3_LBU) || (f3 == F3_LHU);
      end
      return ok;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of right-aligned load data according to the load funct3.
module load_extend
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] data_in,
   output logic [31:0] data_out
);

   // Select extension width and signedness from the load encoding.
   always_comb begin
      data_out = 32'h0000_0000;
      case (funct3)
         F3_LB:   data_out = {{24{data_in[7]}}, data_in[7:0]};
         F3_LH:   data_out = {{16{data_in[15]}}, data_in[15:0]};
         F3_LW:   data_out = data_in;
         F3_LBU:  data_out = {24'h00_0000, data_in[7:0]};
         F3_LHU:  data_out = {16'h0000, data_in[15:0]};
         default: data_out = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage initiator of the dmem bus: one request per handshake, one response per
// request, faults illegal regions/encodings without issuing a memory access.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter logic [15:0] ROM_BASE  = ROM_BASE_DEF,
   parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF,
   parameter logic [15:0] RAM_BASE  = RAM_BASE_DEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_fault,
   output logic        busy,
   output logic [31:0] dmem_address,
   output logic        dmem_enable,
   output logic [31:0] dmem_write_data,
   output logic        dmem_write_enable,
   output logic [2:0]  dmem_write_mode,
   output logic        dmem_read_enable,
   output logic [2:0]  dmem_read_mode,
   input  logic [31:0] dmem_read_data,
   input  logic        dmem_wait
);

   lsu_state_t  state_q, state_d;
   lsu_opcode_t opcode_q, opcode_d;

   logic        region_ok_s;
   logic        legal_s;
   logic [31:0] ext_data_s;

   load_extend u_load_extend (
      .funct3   (opcode_q.funct3),
      .data_in  (dmem_read_data),
      .data_out (ext_data_s)
   );

   // Region decode; ROM is readable only.
   always_comb begin
      region_ok_s = 1'b0;
      if (req_addr[31:16] == ROM_BASE) begin
         region_ok_s = !req_write;
      end else if ((req_addr[31:16] == MMIO_BASE) || (req_addr[31:16] == RAM_BASE)) begin
         region_ok_s = 1'b1;
      end else begin
         region_ok_s = 1'b0;
      end
      legal_s = region_ok_s && funct3_legal(req_write, req_funct3);
   end

   // Next state, response and dmem drive; reset forces the idle output pattern.
   always_comb begin
      state_d           = state_q;
      opcode_d          = opcode_q;
      req_ready         = 1'b1;
      resp_valid        = 1'b0;
      resp_fault        = 1'b0;
      resp_data         = 32'h0000_0000;
      busy              = (state_q != ST_IDLE);
      dmem_address      = 32'h0000_0000;
      dmem_enable       = 1'b0;
      dmem_write_data   = 32'h0000_0000;
      dmem_write_enable = 1'b0;
      dmem_write_mode   = 3'd0;
      dmem_read_enable  = 1'b0;
      dmem_read_mode    = 3'd0;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_IDLE;
         end
         ST_PEND: begin
            if (dmem_wait) begin
               req_ready = 1'b0;
               state_d   = ST_SPLIT;
            end else begin
               resp_valid = 1'b1;
               resp_data  = opcode_q.write ? 32'h0000_0000 : ext_data_s;
               state_d    = ST_IDLE;
            end
         end
         ST_SPLIT: begin
            // Memory has merged both beats by now.
            resp_valid = 1'b1;
            resp_data  = opcode_q.write ? 32'h0000_0000 : ext_data_s;
            state_d    = ST_IDLE;
         end
         ST_FLT: begin
            resp_valid = 1'b1;
            resp_fault = 1'b1;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (req_valid && req_ready) begin
         opcode_d = '{write: req_write, funct3: req_funct3};
         if (legal_s) begin
            dmem_address      = req_addr;
            dmem_enable       = 1'b1;
            dmem_write_enable = req_write;
            dmem_read_enable  = !req_write;
            dmem_write_data   = req_write ? req_wdata : 32'h0000_0000;
            dmem_write_mode   = req_write ? req_funct3 : 3'd0;
            dmem_read_mode    = req_write ? 3'd0 : req_funct3;
            state_d           = ST_PEND;
         end else begin
            state_d = ST_FLT;
         end
      end else begin
         opcode_d = opcode_q;
      end

      if (!reset_n) begin
         state_d           = ST_IDLE;
         opcode_d          = '{write: 1'b0, funct3: 3'd0};
         req_ready         = 1'b1;
         resp_valid        = 1'b0;
         resp_fault        = 1'b0;
         resp_data         = 32'h0000_0000;
         busy              = 1'b0;
         dmem_address      = 32'h0000_0000;
         dmem_enable       = 1'b0;
         dmem_write_data   = 32'h0000_0000;
         dmem_write_enable = 1'b0;
         dmem_write_mode   = 3'd0;
         dmem_read_enable  = 1'b0;
         dmem_read_mode    = 3'd0;
      end else begin
         busy = (state_q != ST_IDLE);
      end
   end

   // State and captured opcode registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         opcode_q <= '{write: 1'b0, funct3: 3'd0};
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-addressed memory model that
// raises dmem_wait on unaligned reads.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_fault, busy;
   logic [31:0] resp_data;
   logic [31:0] dmem_address, dmem_write_data, dmem_read_data;
   logic        dmem_enable, dmem_write_enable, dmem_read_enable, dmem_wait;
   logic [2:0]  dmem_write_mode, dmem_read_mode;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_write         (req_write),
      .req_funct3        (req_funct3),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .resp_valid        (resp_valid),
      .resp_data         (resp_data),
      .resp_fault        (resp_fault),
      .busy              (busy),
      .dmem_address      (dmem_address),
      .dmem_enable       (dmem_enable),
      .dmem_write_data   (dmem_write_data),
      .dmem_write_enable (dmem_write_enable),
      .dmem_write_mode   (dmem_write_mode),
      .dmem_read_enable  (dmem_read_enable),
      .dmem_read_mode    (dmem_read_mode),
      .dmem_read_data    (dmem_read_data),
      .dmem_wait         (dmem_wait)
   );

   typedef struct {
      logic [31:0] data;
      logic        fault;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic [7:0] mem [logic [31:0]];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%08h required=%08h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] rd_byte(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 8'h00;
   endfunction

   // Memory model: sample the bus at negedge, respond just after the next posedge.
   initial begin
      logic        c_en, c_we, c_re, split_pend;
      logic [31:0] c_addr, c_wd, v, split_val;
      logic [2:0]  c_mode;
      int          sz;
      dmem_read_data = 32'h0;
      dmem_wait      = 1'b0;
      split_pend     = 1'b0;
      split_val      = 32'h0;
      forever begin
         @(negedge clk);
         c_en = dmem_enable && reset_n;
         c_we = dmem_write_enable;
         c_re = dmem_read_enable;
         c_addr = dmem_address;
         c_wd = dmem_write_data;
         c_mode = c_we ? dmem_write_mode : dmem_read_mode;
         @(posedge clk);
         #1;
         dmem_wait = 1'b0;
         if (split_pend) begin
            dmem_read_data = split_val;
            split_pend = 1'b0;
         end
         if (c_en) begin
            sz = (c_mode[1:0] == 2'd0) ? 1 : ((c_mode[1:0] == 2'd1) ? 2 : 4);
            if (c_we) begin
               for (int i = 0; i < sz; i++) mem[c_addr + i] = c_wd[8*i +: 8];
            end else if (c_re) begin
               v = 32'h0;
               for (int i = 0; i < sz; i++) v[8*i +: 8] = rd_byte(c_addr + i);
               if ((sz == 2 && c_addr[0]) || (sz == 4 && c_addr[1:0] != 2'd0)) begin
                  dmem_wait = 1'b1;
                  dmem_read_data = 32'hA5A5_A5A5;
                  split_pend = 1'b1;
                  split_val = v;
               end else begin
                  dmem_read_data = v;
               end
            end
         end
      end
   end

   // Monitor: every response is popped from the scoreboard and compared.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               chk("spurious_resp", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("resp_data", resp_data, e.data);
               chk("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
               chk("resp_cycle", cyc, e.cyc);
            end
         end
      end
   end

   // Issue one request (called at posedge+2); returns at posedge+2 after the fire edge.
   task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_data,
                        input logic exp_fault, input int lat, input logic expect_resp,
                        output int fire_cyc);
      exp_t e;
      bit   fired = 0;
      req_valid = 1'b1;
      req_write = wr;
      req_funct3 = f3;
      req_addr = addr;
      req_wdata = wd;
      fire_cyc = -1;
      for (int n = 0; n < 20 && !fired; n++) begin
         @(negedge clk);
         if (req_ready === 1'b1) begin
            fired = 1;
            fire_cyc = cyc;
            chk("fire_enable", {31'd0, dmem_enable}, {31'd0, !exp_fault});
            chk("fire_wen", {31'd0, dmem_write_enable}, {31'd0, wr && !exp_fault});
            chk("fire_ren", {31'd0, dmem_read_enable}, {31'd0, !wr && !exp_fault});
            if (!exp_fault) begin
               chk("fire_addr", dmem_address, addr);
               chk("fire_mode", {29'd0, wr ? dmem_write_mode : dmem_read_mode}, {29'd0, f3});
               if (wr) chk("fire_wdata", dmem_write_data, wd);
            end
            if (expect_resp) begin
               e.data = exp_data;
               e.fault = exp_fault;
               e.cyc = cyc + lat;
               sb_q.push_back(e);
            end
         end
         @(posedge clk);
         #2;
      end
      if (!fired) chk("req_ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
   endtask

   initial begin
      int fc, f1, f2, f3c;
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int fc, f1, f2, f3c;
      reset_n = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_funct3 = 3'd0;
      req_addr = 32'h0;
      req_wdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_enable", {31'd0, dmem_enable}, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      #2;

      // Store then load word, sub-word loads with sign/zero extension.
      issue(1'b1, 3'd2, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 1, 1'b1, fc);
      issue(1'b0, 3'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1, 1'b1, fc);
      issue(1'b1, 3'd0, 32'h8000_0003, 32'h0000_0080, 32'h0, 1'b0, 1, 1'b1, fc);
      issue(1'b0, 3'd0, 32'h8000_0003, 32'h0, 32'hFFFF_FF80, 1'b0, 1, 1'b1, fc);
      issue(1'b0, 3'd4, 32'h8000_0003, 32'h0, 32'h0000_0080, 1'b0, 1, 1'b1, fc);
      issue(1'b0, 3'd1, 32'h8000_0010, 32'h0, 32'hFFFF_BEEF, 1'b0, 1, 1'b1, fc);
      issue(1'b0, 3'd5, 32'h8000_0010, 32'h0, 32'h0000_BEEF, 1'b0, 1, 1'b1, fc);

      // Unaligned word and halfword reads go through SPLIT.
      issue(1'b1, 3'd2, 32'h8000_0020, 32'h4433_2211, 32'h0, 1'b0, 1, 1'b1, fc);
      issue(1'b1, 3'd2, 32'h8000_0024, 32'h8877_6655, 32'h0, 1'b0, 1, 1'b1, fc);
      issue(1'b0, 3'd2, 32'h8000_0021, 32'h0, 32'h5544_3322, 1'b0, 2, 1'b1, fc);
      @(negedge clk);
      chk("wait_ready", {31'd0, req_ready}, 32'd0);
      chk("wait_enable", {31'd0, dmem_enable}, 32'd0);
      chk("wait_busy", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #2;
      issue(1'b0, 3'd1, 32'h8000_0023, 32'h0, 32'h0000_5544, 1'b0, 2, 1'b1, fc);
      repeat (2) @(posedge clk);
      #2;

      // Faults: ROM store, bad funct3, unmapped region, bad store funct3.
      issue(1'b1, 3'd2, 32'h0000_0100, 32'h1234_5678, 32'h0, 1'b1, 1, 1'b1, fc);
      issue(1'b0, 3'd3, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 1, 1'b1, fc);
      issue(1'b0, 3'd2, 32'h1234_0000, 32'h0, 32'h0, 1'b1, 1, 1'b1, fc);
      issue(1'b1, 3'd2, 32'h1234_0000, 32'h1, 32'h0, 1'b1, 1, 1'b1, fc);
      issue(1'b1, 3'd4, 32'h8000_0000, 32'h1, 32'h0, 1'b1, 1, 1'b1, fc);

      // MMIO round trip and ROM load.
      issue(1'b1, 3'd2, 32'h7000_0000, 32'hCAFE_F00D, 32'h0, 1'b0, 1, 1'b1, fc);
      issue(1'b0, 3'd2, 32'h7000_0000, 32'h0, 32'hCAFE_F00D, 1'b0, 1, 1'b1, fc);
      issue(1'b0, 3'd2, 32'h0000_0100, 32'h0, 32'h0000_0000, 1'b0, 1, 1'b1, fc);

      // Back-to-back aligned loads, one per cycle.
      issue(1'b0, 3'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1, 1'b1, f1);
      issue(1'b0, 3'd2, 32'h8000_0020, 32'h0, 32'h4433_2211, 1'b0, 1, 1'b1, f2);
      issue(1'b0, 3'd2, 32'h8000_0024, 32'h0, 32'h8877_6655, 1'b0, 1, 1'b1, f3c);
      chk("b2b_gap1", f2 - f1, 32'd1);
      chk("b2b_gap2", f3c - f2, 32'd1);
      repeat (2) @(posedge clk);
      #2;

      // Reset during PEND drops the response.
      issue(1'b0, 3'd2, 32'h8000_0010, 32'h0, 32'h0, 1'b0, 1, 1'b0, fc);
      reset_n = 1'b0;
      @(negedge clk);
      chk("rstpend_resp_valid", {31'd0, resp_valid}, 32'd0);
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      @(negedge clk);
      chk("rstpend_busy", {31'd0, busy}, 32'd0);
      chk("rstpend_ready", {31'd0, req_ready}, 32'd1);
      chk("rstpend_resp_valid2", {31'd0, resp_valid}, 32'd0);
      @(posedge clk);
      #2;
      issue(1'b0, 3'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1, 1'b1, fc);

      repeat (4) @(posedge clk);
      chk("scoreboard_drained", sb_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
